// File: rtl/uncached_access_unit_if.sv
// Signal bundle for the uncached access unit: memory-stage request/response,
// PMA checker side-band and single-beat system bus.
interface uncached_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_width;
    logic        req_unsigned;
    logic [28:0] req_addr;
    logic [31:0] req_wdata;

    logic        pma_read;
    logic        pma_write;
    logic [1:0]  pma_width;
    logic [16:0] pma_ppn;
    logic        pma_cacheable;
    logic        pma_error;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_cacheable;
    logic [1:0]  resp_cause;
    logic [31:0] resp_rdata;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [28:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_resp_valid;
    logic        bus_resp_err;
    logic [31:0] bus_rdata;

    // The unit itself
    modport slave (
        input  req_valid, req_read, req_write, req_width, req_unsigned, req_addr, req_wdata,
        output req_ready,
        output pma_read, pma_write, pma_width, pma_ppn,
        input  pma_cacheable, pma_error,
        output resp_valid, resp_cacheable, resp_cause, resp_rdata,
        input  resp_ready,
        output bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_req_ready, bus_resp_valid, bus_resp_err, bus_rdata
    );

    // Surrounding environment: memory stage, PMA checker and bus arbiter
    modport master (
        output req_valid, req_read, req_write, req_width, req_unsigned, req_addr, req_wdata,
        input  req_ready,
        input  pma_read, pma_write, pma_width, pma_ppn,
        output pma_cacheable, pma_error,
        input  resp_valid, resp_cacheable, resp_cause, resp_rdata,
        output resp_ready,
        input  bus_req_valid, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_req_ready, bus_resp_valid, bus_resp_err, bus_rdata
    );
endinterface

// File: rtl/uncached_access_unit.sv
// Sequences one load/store through the PMA check, then faults, bounces it to
// the cache path, or performs it as a single-beat MMIO bus transaction.
module uncached_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_core,
    input  logic                   reset_n,
    uncached_access_unit_if.slave  bus_if
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_EVAL,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_RESP
    } state_e;

    localparam logic [1:0] CAUSE_OK      = 2'd0;
    localparam logic [1:0] CAUSE_ACCESS  = 2'd1;
    localparam logic [1:0] CAUSE_MISALGN = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [1:0]  width_q, width_d;
    logic        uns_q, uns_d;
    logic [28:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  cause_q, cause_d;
    logic        cacheable_q, cacheable_d;
    logic [31:0] rdata_q, rdata_d;

    logic        misaligned;
    logic        in_bus_req;
    logic        pma_active;

    function automatic logic [3:0] lane_enables(input logic [1:0] width, input logic [1:0] off);
        logic [3:0] be;
        case (width)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [31:0] wdata, input logic [1:0] off);
        return wdata << {off, 3'b000};
    endfunction

    // Move the addressed lane down to bit 0, then sign- or zero-extend to 32 bits
    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] width, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (width)
            2'd0:    res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign misaligned = (width_q == 2'd3)
                     || ((width_q == 2'd1) && addr_q[0])
                     || ((width_q == 2'd2) && (addr_q[1:0] != 2'b00));

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            width_q     <= 2'd0;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cause_q     <= CAUSE_OK;
            cacheable_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            width_q     <= width_d;
            uns_q       <= uns_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cause_q     <= cause_d;
            cacheable_q <= cacheable_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        width_d     = width_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cause_d     = cause_q;
        cacheable_d = cacheable_q;
        rdata_d     = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus_if.req_valid) begin
                    rd_d    = bus_if.req_read;
                    wr_d    = bus_if.req_write;
                    width_d = bus_if.req_width;
                    uns_d   = bus_if.req_unsigned;
                    addr_d  = bus_if.req_addr;
                    wdata_d = bus_if.req_wdata;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: state_d = S_EVAL;
            // PMA result is valid here; misalignment outranks a PMA fault
            S_EVAL: begin
                if (misaligned) begin
                    cause_d = CAUSE_MISALGN;
                    state_d = S_RESP;
                end else if (bus_if.pma_error) begin
                    cause_d = CAUSE_ACCESS;
                    state_d = S_RESP;
                end else if (bus_if.pma_cacheable) begin
                    cause_d     = CAUSE_OK;
                    cacheable_d = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    state_d = S_BUS_REQ;
                end
            end
            S_BUS_REQ: begin
                if (bus_if.bus_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_BUS_WAIT;
                end
            end
            // A response arriving on the timeout cycle still wins
            S_BUS_WAIT: begin
                if (bus_if.bus_resp_valid) begin
                    cause_d = bus_if.bus_resp_err ? CAUSE_ACCESS : CAUSE_OK;
                    if (rd_q && !bus_if.bus_resp_err) begin
                        rdata_d = extend_load(bus_if.bus_rdata, addr_q[1:0], width_q, uns_q);
                    end
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                if (bus_if.resp_ready) begin
                    cause_d     = CAUSE_OK;
                    cacheable_d = 1'b0;
                    rdata_d     = '0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pma_active = (state_q != S_IDLE);
    assign in_bus_req = (state_q == S_BUS_REQ);

    assign bus_if.req_ready      = (state_q == S_IDLE);

    assign bus_if.pma_read       = pma_active & rd_q;
    assign bus_if.pma_write      = pma_active & wr_q;
    assign bus_if.pma_width      = pma_active ? width_q : 2'd0;
    assign bus_if.pma_ppn        = pma_active ? addr_q[28:12] : 17'd0;

    assign bus_if.bus_req_valid  = in_bus_req;
    assign bus_if.bus_we         = in_bus_req & wr_q;
    assign bus_if.bus_addr       = in_bus_req ? {addr_q[28:2], 2'b00} : 29'd0;
    assign bus_if.bus_be         = in_bus_req ? lane_enables(width_q, addr_q[1:0]) : 4'd0;
    assign bus_if.bus_wdata      = in_bus_req ? lane_wdata(wdata_q, addr_q[1:0]) : 32'd0;

    assign bus_if.resp_valid     = (state_q == S_RESP);
    assign bus_if.resp_cause     = cause_q;
    assign bus_if.resp_cacheable = cacheable_q;
    assign bus_if.resp_rdata     = rdata_q;

endmodule

// File: tb/tb_uncached_access_unit.sv
// Bench for uncached_access_unit: directed vector table, hand-written corner
// sequences and randomized transactions checked against an arithmetic model.
module tb_uncached_access_unit;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uncached_access_unit_if uif();

    uncached_access_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk_core (clk),
        .reset_n  (rst_n),
        .bus_if   (uif)
    );

    typedef struct {
        logic        rd;
        logic [1:0]  width;
        logic        uns;
        logic [28:0] addr;
        logic [31:0] wdata;
        logic        pcache;
        logic        perr;
        logic [31:0] brdata;
        logic        berr;
        int          gdelay;
        int          rdelay;
        int          stall;
        logic [1:0]  ecause;
        logic        ecache;
        logic [31:0] erdata;
        logic        ebus;
        logic [3:0]  ebe;
        logic [28:0] ebaddr;
        logic [31:0] ewdata;
        int          elat;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t dv(input logic rd, input logic [1:0] width, input logic uns,
                                input logic [28:0] addr, input logic [31:0] wdata,
                                input logic pc, input logic pe, input logic [31:0] brd,
                                input logic berr, input int g, input int r,
                                input logic [1:0] ec, input logic ecache, input logic [31:0] erd,
                                input logic ebus, input logic [3:0] ebe, input logic [28:0] eba,
                                input logic [31:0] ewd, input int elat);
        vec_t v;
        v.rd = rd; v.width = width; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.pcache = pc; v.perr = pe; v.brdata = brd; v.berr = berr;
        v.gdelay = g; v.rdelay = r; v.stall = 1;
        v.ecause = ec; v.ecache = ecache; v.erdata = erd; v.ebus = ebus;
        v.ebe = ebe; v.ebaddr = eba; v.ewdata = ewd; v.elat = elat;
        return v;
    endfunction

    // Reference model: derives every expected field from the access rules with plain arithmetic
    function automatic vec_t model(input vec_t v);
        vec_t o;
        int off, nb;
        longint unsigned x;
        o = v;
        off = int'(v.addr % 4);
        o.ecause = 2'd0; o.ecache = 1'b0; o.erdata = 32'd0; o.ebus = 1'b0;
        o.ebe = 4'd0; o.ebaddr = 29'd0; o.ewdata = 32'd0; o.elat = 3;
        if (v.width == 2'd3 || (v.addr % (29'd1 << v.width)) != 0) begin
            o.ecause = 2'd2;
        end else if (v.perr) begin
            o.ecause = 2'd1;
        end else if (v.pcache) begin
            o.ecache = 1'b1;
        end else begin
            nb = 1 << v.width;
            o.ebus = 1'b1;
            o.ebe = 4'((longint'(1 << nb) - 1) << off);
            o.ebaddr = v.addr - 29'(off);
            o.ewdata = 32'((longint'(v.wdata) << (8 * off)) % 64'h1_0000_0000);
            if (v.rdelay >= T) begin
                o.ecause = 2'd3;
                o.elat = 3 + (v.gdelay + 1) + T;
            end else begin
                o.ecause = v.berr ? 2'd1 : 2'd0;
                o.elat = 3 + (v.gdelay + 1) + v.rdelay + 1;
                if (v.rd && !v.berr) begin
                    x = (longint'(v.brdata) >> (8 * off)) % (64'd1 << (8 * nb));
                    if (!v.uns && x >= (64'd1 << (8 * nb - 1)))
                        x = x + 64'h1_0000_0000 - (64'd1 << (8 * nb));
                    o.erdata = x[31:0];
                end
            end
        end
        return o;
    endfunction

    task automatic run(input vec_t v, input string tag);
        int cyc, reqn, waitn;
        bit granted, grant_pend, bus_seen, got_resp, bus_stable, hold_ok;
        logic [3:0] be0; logic [28:0] ba0; logic [31:0] wd0; logic we0;
        logic [1:0] cause0; logic [31:0] rdata0;
        cyc = 0; reqn = 0; waitn = 0;
        granted = 0; grant_pend = 0; bus_seen = 0; got_resp = 0; bus_stable = 1; hold_ok = 1;
        be0 = '0; ba0 = '0; wd0 = '0; we0 = 1'b0;
        @(negedge clk);
        chk({tag, " req_ready"}, 32'(uif.req_ready), 32'd1);
        uif.req_read = v.rd; uif.req_write = !v.rd; uif.req_width = v.width;
        uif.req_unsigned = v.uns; uif.req_addr = v.addr; uif.req_wdata = v.wdata;
        uif.pma_cacheable = v.pcache; uif.pma_error = v.perr;
        uif.req_valid = 1'b1;
        @(posedge clk);
        #1 uif.req_valid = 1'b0;
        uif.req_addr = 29'($urandom);
        while (!got_resp && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk({tag, " pma_ppn"}, 32'(uif.pma_ppn), 32'(v.addr >> 12));
                chk({tag, " pma_rw"}, {30'd0, uif.pma_read, uif.pma_write}, {30'd0, v.rd, !v.rd});
            end
            if (grant_pend) begin granted = 1; grant_pend = 0; end
            if (granted) begin
                uif.bus_resp_valid = (waitn == v.rdelay);
                uif.bus_resp_err = v.berr;
                uif.bus_rdata = v.brdata;
                waitn++;
            end else begin
                uif.bus_resp_valid = 1'b0;
            end
            if (uif.bus_req_valid) begin
                if (!bus_seen) begin
                    be0 = uif.bus_be; ba0 = uif.bus_addr; wd0 = uif.bus_wdata; we0 = uif.bus_we;
                end else if (be0 !== uif.bus_be || ba0 !== uif.bus_addr ||
                             wd0 !== uif.bus_wdata || we0 !== uif.bus_we) begin
                    bus_stable = 0;
                end
                bus_seen = 1;
                reqn++;
                uif.bus_req_ready = (reqn == v.gdelay + 1);
                if (uif.bus_req_ready) grant_pend = 1;
            end else begin
                uif.bus_req_ready = 1'b0;
            end
            if (uif.resp_valid) begin
                got_resp = 1;
                chk({tag, " latency"}, 32'(cyc), 32'(v.elat));
                chk({tag, " cause"}, 32'(uif.resp_cause), 32'(v.ecause));
                chk({tag, " cacheable"}, 32'(uif.resp_cacheable), 32'(v.ecache));
                chk({tag, " rdata"}, uif.resp_rdata, v.erdata);
            end
        end
        uif.bus_resp_valid = 1'b0;
        uif.bus_req_ready = 1'b0;
        if (!got_resp) chk({tag, " resp_arrived"}, 32'd0, 32'd1);
        chk({tag, " bus_activity"}, 32'(bus_seen), 32'(v.ebus));
        if (v.ebus && bus_seen) begin
            chk({tag, " bus_be"}, 32'(be0), 32'(v.ebe));
            chk({tag, " bus_addr"}, 32'(ba0), 32'(v.ebaddr));
            chk({tag, " bus_we"}, 32'(we0), 32'(!v.rd));
            chk({tag, " bus_wdata"}, wd0, v.ewdata);
            chk({tag, " bus_stable"}, 32'(bus_stable), 32'd1);
        end
        if (got_resp) begin
            cause0 = uif.resp_cause; rdata0 = uif.resp_rdata;
            repeat (v.stall) begin
                @(negedge clk);
                if (!uif.resp_valid || uif.resp_cause !== cause0 || uif.resp_rdata !== rdata0)
                    hold_ok = 0;
            end
            if (v.stall > 0) chk({tag, " resp_hold"}, 32'(hold_ok), 32'd1);
            uif.resp_ready = 1'b1;
            @(posedge clk);
            #1 uif.resp_ready = 1'b0;
            @(negedge clk);
            chk({tag, " resp_done"}, {30'd0, uif.resp_valid, uif.req_ready}, 32'b01);
        end
    endtask

    initial begin
        vec_t v;
        int n;
        bit seen;
        uif.req_valid = 0; uif.req_read = 0; uif.req_write = 0; uif.req_width = 0;
        uif.req_unsigned = 0; uif.req_addr = 0; uif.req_wdata = 0;
        uif.pma_cacheable = 0; uif.pma_error = 0; uif.resp_ready = 0;
        uif.bus_req_ready = 0; uif.bus_resp_valid = 0; uif.bus_resp_err = 0; uif.bus_rdata = 0;

        // rd width uns addr wdata pc pe brdata berr g r | cause cache rdata bus be baddr wdata lat
        tbl[0]  = dv(1, 2, 0, 29'h2000010, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0, 0,
                     2'd0, 0, 32'hDEADBEEF, 1, 4'b1111, 29'h2000010, 32'h0, 5);
        tbl[1]  = dv(1, 0, 0, 29'h2000003, 32'h0, 0, 0, 32'h80000000, 0, 0, 0,
                     2'd0, 0, 32'hFFFFFF80, 1, 4'b1000, 29'h2000000, 32'h0, 5);
        tbl[2]  = dv(1, 0, 1, 29'h2000003, 32'h0, 0, 0, 32'h80000000, 0, 0, 0,
                     2'd0, 0, 32'h00000080, 1, 4'b1000, 29'h2000000, 32'h0, 5);
        tbl[3]  = dv(0, 1, 0, 29'h2000002, 32'h1234, 0, 1, 32'h0, 0, 0, 0,
                     2'd1, 0, 32'h0, 0, 4'b0, 29'h0, 32'h0, 3);
        tbl[4]  = dv(1, 2, 0, 29'h10000004, 32'h0, 1, 0, 32'h0, 0, 0, 0,
                     2'd0, 1, 32'h0, 0, 4'b0, 29'h0, 32'h0, 3);
        tbl[5]  = dv(1, 1, 0, 29'h2000001, 32'h0, 0, 1, 32'h0, 0, 0, 0,
                     2'd2, 0, 32'h0, 0, 4'b0, 29'h0, 32'h0, 3);
        tbl[6]  = dv(1, 2, 0, 29'h2000020, 32'h0, 0, 0, 32'h55AA55AA, 0, 0, 99,
                     2'd3, 0, 32'h0, 1, 4'b1111, 29'h2000020, 32'h0, 8);
        tbl[7]  = dv(0, 1, 0, 29'h2000006, 32'h0000ABCD, 0, 0, 32'h0, 0, 2, 1,
                     2'd0, 0, 32'h0, 1, 4'b1100, 29'h2000004, 32'hABCD0000, 8);
        tbl[8]  = dv(1, 3, 0, 29'h2000000, 32'h0, 0, 0, 32'h0, 0, 0, 0,
                     2'd2, 0, 32'h0, 0, 4'b0, 29'h0, 32'h0, 3);
        tbl[9]  = dv(1, 2, 0, 29'h2000040, 32'h0, 0, 0, 32'h12345678, 1, 1, 2,
                     2'd1, 0, 32'h0, 1, 4'b1111, 29'h2000040, 32'h0, 8);
        tbl[10] = dv(1, 2, 0, 29'h2000044, 32'h0, 0, 0, 32'h11223344, 0, 0, 3,
                     2'd0, 0, 32'h11223344, 1, 4'b1111, 29'h2000044, 32'h0, 8);
        tbl[11] = dv(1, 1, 0, 29'h2000002, 32'h0, 0, 0, 32'hF00D1234, 0, 0, 0,
                     2'd0, 0, 32'hFFFFF00D, 1, 4'b1100, 29'h2000000, 32'h0, 5);

        #2;
        chk("reset req_ready", 32'(uif.req_ready), 32'd1);
        chk("reset outputs", {27'd0, uif.resp_valid, uif.bus_req_valid, uif.pma_read,
                              uif.pma_write, uif.resp_cacheable}, 32'd0);
        chk("reset pma_ppn", 32'(uif.pma_ppn), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Late bus response after a timeout must be ignored
        run(tbl[6], "timeout");
        @(negedge clk);
        uif.bus_resp_valid = 1'b1; uif.bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        uif.bus_resp_valid = 1'b0;
        chk("stray resp_valid", 32'(uif.resp_valid), 32'd0);
        chk("stray req_ready", 32'(uif.req_ready), 32'd1);
        run(tbl[0], "after_stray");

        // Reset while waiting for the bus response abandons the access
        @(negedge clk);
        uif.req_read = 1; uif.req_write = 0; uif.req_width = 2; uif.req_unsigned = 0;
        uif.req_addr = 29'h2000010; uif.pma_cacheable = 0; uif.pma_error = 0;
        uif.req_valid = 1'b1;
        @(posedge clk);
        #1 uif.req_valid = 1'b0;
        seen = 0; n = 0;
        while (!seen && n < 10) begin
            @(negedge clk); n++;
            seen = uif.bus_req_valid;
        end
        chk("rst bus_req_seen", 32'(seen), 32'd1);
        uif.bus_req_ready = 1'b1;
        @(negedge clk);
        uif.bus_req_ready = 1'b0;
        chk("rst in_wait", {30'd0, uif.bus_req_valid, uif.resp_valid}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst req_ready", 32'(uif.req_ready), 32'd1);
        chk("rst quiet", {29'd0, uif.resp_valid, uif.bus_req_valid, uif.pma_read}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        uif.bus_resp_valid = 1'b1; uif.bus_rdata = 32'h0BADF00D;
        @(negedge clk);
        uif.bus_resp_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst no_resp", {30'd0, uif.resp_valid, uif.req_ready}, 32'b01);
        run(tbl[1], "after_rst");

        for (int i = 0; i < 60; i++) begin
            v.rd = 1'($urandom);
            v.width = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            v.uns = 1'($urandom);
            v.addr = 29'($urandom);
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            if (v.width == 2'd0) v.wdata = v.wdata & 32'hFF;
            if (v.width == 2'd1) v.wdata = v.wdata & 32'hFFFF;
            v.pcache = ($urandom_range(0, 3) == 0);
            v.perr = ($urandom_range(0, 3) == 0);
            v.brdata = $urandom;
            v.berr = ($urandom_range(0, 7) == 0);
            v.gdelay = $urandom_range(0, 3);
            v.rdelay = $urandom_range(0, 5);
            v.stall = $urandom_range(0, 2);
            run(model(v), $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uncached_access_unit.md
Name: uncached_access_unit

Overview:
- Sequences one load/store at a time from the memory stage through the PMA check.
- Drives the physical page number and access type into the PMA checker, then acts on its registered result one cycle later:
  - faults on a PMA error or misalignment;
  - bounces cacheable accesses back to the cache path;
  - performs non-cacheable accesses (MMIO) as single-beat transactions on the system bus.
- Sits between the memory-stage request port and the bus arbiter, alongside the PMA checker.

Parameters:
TIMEOUT_CYCLES, 255, cycles to wait for bus_resp_valid after the bus accepts a request before aborting with a timeout fault (valid range 1..65535).

Ports:
clk_core  in  1  core clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  memory-stage request valid
req_ready  out  1  unit can accept a request
req_read  in  1  load
req_write  in  1  store (exactly one of read/write is set when req_valid)
req_width  in  2  0=byte, 1=half, 2=word; 3 is illegal
req_unsigned  in  1  zero-extend load data (else sign-extend)
req_addr  in  29  physical byte address
req_wdata  in  32  store data, right-aligned
pma_read  out  1  to PMA checker
pma_write  out  1  to PMA checker
pma_width  out  2  to PMA checker
pma_ppn  out  17  to PMA checker, latched addr[28:12]
pma_cacheable  in  1  PMA result, registered
pma_error  in  1  PMA result, registered
resp_valid  out  1  response valid
resp_ready  in  1  memory stage accepts response
resp_cacheable  out  1  no bus access made; reissue through the cache
resp_cause  out  2  0=ok, 1=access fault, 2=misaligned, 3=bus timeout
resp_rdata  out  32  aligned, extended load data (0 for stores and faults)
bus_req_valid  out  1  bus request
bus_req_ready  in  1  bus accepts request
bus_we  out  1  write
bus_addr  out  29  word-aligned address ({addr[28:2],2'b00})
bus_be  out  4  byte enables
bus_wdata  out  32  lane-shifted store data
bus_resp_valid  in  1  bus response
bus_resp_err  in  1  bus error with response
bus_rdata  in  32  bus read word

Behaviour:
States: IDLE, CHECK, EVAL, BUS_REQ, BUS_WAIT, RESP.

Reset:
- state=IDLE.
- All outputs 0, except req_ready=1 in IDLE.
- Latched request, counter and response registers cleared.
- Reset mid-transaction abandons it; no response is produced.

IDLE:
- req_ready=1.
- On req_valid: latch read/write/width/unsigned/addr/wdata, then go to CHECK.

PMA interface:
- pma_* outputs are driven from the latched request in every state except IDLE (0 in IDLE).

CHECK:
- One cycle; the PMA checker samples pma_ppn at the end of this cycle.

EVAL (PMA result valid), checked in priority order:
1. width==3, or misaligned (half with addr[0]!=0; word with addr[1:0]!=0): cause=2, go to RESP.
2. Else pma_error: cause=1, go to RESP.
3. Else pma_cacheable: resp_cacheable=1, cause=0, go to RESP.
4. Else go to BUS_REQ.

BUS_REQ:
- bus_req_valid=1, with bus_we/addr/be/wdata held stable until bus_req_ready.
- On the handshake: clear the counter, go to BUS_WAIT.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Write data: bus_wdata = req_wdata << (8*addr[1:0]).

BUS_WAIT:
- Counter increments each cycle.
- On bus_resp_valid:
  - cause = bus_resp_err ? 1 : 0.
  - For a load without error: rdata = bus_rdata >> (8*addr[1:0]), truncated to width, then sign- or zero-extended.
  - Go to RESP.
- If the counter reaches TIMEOUT_CYCLES without a response: cause=3, go to RESP.
- Response wins if bus_resp_valid arrives in the same cycle as the timeout.

RESP:
- resp_valid=1, with cause/cacheable/rdata held until resp_ready.
- On resp_ready: clear the response registers, go to IDLE.
- Latency, accept to resp_valid:
  - fault or cacheable: 3 cycles;
  - bus access: 3 + grant wait + response wait + 1.

Stray responses:
- bus_resp_valid outside BUS_WAIT (e.g. a late response after a timeout) is ignored.

Test Plan:
- Word load at 0x2000010, PMA non-cacheable/no error, bus_rdata=0xDEADBEEF one cycle after grant -> bus_be=1111, bus_addr=0x2000010; resp_valid with rdata=0xDEADBEEF, cause=0.
- Signed byte load at 0x2000003 with bus_rdata=0x80000000 -> bus_be=1000, rdata=0xFFFFFF80; same access with req_unsigned=1 -> 0x00000080.
- Half store at 0x2000002 with wdata=0x1234 and pma_error=1 -> no bus_req_valid; cause=1, rdata=0.
- Word load at 0x1000_0004 with pma_cacheable=1 -> no bus activity; resp_cacheable=1, cause=0, resp_valid exactly 3 cycles after accept.
- Half load at 0x2000001 -> cause=2 even though pma_error=1; no bus activity.
- TIMEOUT_CYCLES=4, bus grants but never responds -> cause=3 after 4 wait cycles; a later bus_resp_valid is ignored; next request is accepted normally. Also assert reset_n in BUS_WAIT -> IDLE, req_ready=1, no resp_valid.
